param_coeff_loader: RTL and testbench

PARAM_COEFF_LOADER -- requirements
Module: param_coeff_loader

---
 rtl/coeff_loader_pkg.sv | 17 +
 rtl/wait_timer.sv | 31 +++
 rtl/param_coeff_loader.sv | 103 ++++++++++
 tb/tb_param_coeff_loader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/coeff_loader_pkg.sv
// Shared types and default sizing for the coefficient loader.
// The optional WAIT timeout is enabled with COEFF_LOADER_TIMEOUT_EN.
package coeff_loader_pkg;

    localparam int unsigned DEFAULT_NUM_COEFFS     = 4;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int unsigned WAIT_CNT_W             = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        CLEAR,
        ERR
    } state_t;

endpackage

// File: rtl/wait_timer.sv
// Counts busy cycles inside WAIT; at_limit flags the cycle whose increment reaches the limit.
// Only instantiated when COEFF_LOADER_TIMEOUT_EN is defined.
module wait_timer
    import coeff_loader_pkg::*;
#(
    parameter int unsigned WIDTH = WAIT_CNT_W
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             at_limit
);

    logic [WIDTH-1:0] count;

    // Saturates at the limit so the count can never wrap.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != limit)) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = enable && (count == (limit - 1'b1));

endmodule

// File: rtl/param_coeff_loader.sv
// Sequences NUM_COEFFS coefficient loads into a datapath gated by modwait.
// Define COEFF_LOADER_TIMEOUT_EN to bound each WAIT to TIMEOUT_CYCLES busy cycles.
module param_coeff_loader
    import coeff_loader_pkg::*;
#(
    parameter  int unsigned NUM_COEFFS     = DEFAULT_NUM_COEFFS,
    parameter  int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int unsigned IDX_W          = $clog2(NUM_COEFFS)
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             new_coefficient_set,
    input  logic             modwait,
    output logic             load_coeff,
    output logic [IDX_W-1:0] coefficient_num,
    output logic             clear_new_coefficient,
    output logic             busy,
    output logic             timeout_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFFS - 1);

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic             timeout_hit;

`ifdef COEFF_LOADER_TIMEOUT_EN
    localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(TIMEOUT_CYCLES);

    logic timeout_err_q;

    wait_timer #(.WIDTH(WAIT_CNT_W)) u_wait_timer (
        .clk      (clk),
        .n_reset  (n_reset),
        .clear    (state == LOAD),
        .enable   ((state == WAIT) && modwait),
        .limit    (LIMIT),
        .at_limit (timeout_hit)
    );

    // Sticky until the next sequence actually starts.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            timeout_err_q <= 1'b0;
        end else if ((state == IDLE) && (state_next == LOAD)) begin
            timeout_err_q <= 1'b0;
        end else if (state_next == ERR) begin
            timeout_err_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        unique case (state)
            IDLE: begin
                if (new_coefficient_set && !modwait) begin
                    state_next = LOAD;
                    idx_next   = '0;
                end
            end
            LOAD: begin
                state_next = (idx == LAST_IDX) ? CLEAR : WAIT;
            end
            WAIT: begin
                if (!modwait) begin
                    state_next = LOAD;
                    idx_next   = idx + 1'b1;
                end else if (timeout_hit) begin
                    state_next = ERR;
                end
            end
            CLEAR, ERR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign load_coeff            = (state == LOAD);
    assign clear_new_coefficient = (state == CLEAR) || (state == ERR);
    assign busy                  = (state != IDLE);
    assign coefficient_num       = (state == IDLE) ? '0 : idx;

endmodule

// File: tb/tb_param_coeff_loader.sv
// Randomised scoreboard bench for param_coeff_loader (NUM_COEFFS=5, TIMEOUT_CYCLES=8).
// Expected strobes are timestamped from the chosen modwait schedule; a monitor pops and compares.
module tb_param_coeff_loader;

    localparam int unsigned N  = 5;
    localparam int unsigned T  = 8;
    localparam int unsigned IW = $clog2(N);

    logic          clk = 1'b0;
    logic          n_reset = 1'b0;
    logic          new_coefficient_set = 1'b0;
    logic          modwait = 1'b0;
    logic          load_coeff;
    logic [IW-1:0] coefficient_num;
    logic          clear_new_coefficient;
    logic          busy;
    logic          timeout_err;

    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        bit          is_clear;
        int unsigned idx;
        int unsigned cyc;
        bit          err;
    } ev_t;

    ev_t sb[$];

    param_coeff_loader #(.NUM_COEFFS(N), .TIMEOUT_CYCLES(T)) dut (
        .clk                   (clk),
        .n_reset               (n_reset),
        .new_coefficient_set   (new_coefficient_set),
        .modwait               (modwait),
        .load_coeff            (load_coeff),
        .coefficient_num       (coefficient_num),
        .clear_new_coefficient (clear_new_coefficient),
        .busy                  (busy),
        .timeout_err           (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_load"}, 32'(load_coeff), 0);
        check({tag, "_clear"}, 32'(clear_new_coefficient), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_num"}, 32'(coefficient_num), 0);
        check({tag, "_err"}, 32'(timeout_err), 0);
    endtask

    // Monitor: every strobe must match the head of the scoreboard, including its cycle stamp.
    always @(negedge clk) begin
        if (load_coeff === 1'b1 || clear_new_coefficient === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: got load=%0b clr=%0b idx=%0d cycle=%0d expected no strobe",
                         load_coeff, clear_new_coefficient, coefficient_num, cyc);
            end else begin
                ev_t e;
                e = sb.pop_front();
                checks++;
                if (load_coeff !== !e.is_clear || clear_new_coefficient !== e.is_clear ||
                    coefficient_num !== IW'(e.idx) || cyc != e.cyc ||
                    timeout_err !== e.err || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL strobe: got load=%0b clr=%0b idx=%0d cycle=%0d err=%0b busy=%0b expected load=%0b clr=%0b idx=%0d cycle=%0d err=%0b busy=1",
                             load_coeff, clear_new_coefficient, coefficient_num, cyc, timeout_err, busy,
                             !e.is_clear, e.is_clear, e.idx, e.cyc, e.err);
                end
            end
        end
    end

    // Entered and left in the IDLE cycle, #1 after a rising edge. last_k < N-1 aborts by reset in WAIT.
    task automatic run_seq(input int unsigned stall, input bit drop_req, input bit chain,
                           input int unsigned last_k, input int unsigned gap_fix, input bit use_fix);
        int unsigned gaps[N];
        int unsigned t;
        for (int k = 0; k < N; k++) gaps[k] = use_fix ? gap_fix : $urandom_range(0, 6);
        new_coefficient_set = 1'b1;
        repeat (stall) begin
            modwait = 1'b1;
            @(posedge clk); #1;
        end
        modwait = 1'b0;
        t = cyc + 1;
        for (int unsigned k = 0; k <= last_k; k++) begin
            sb.push_back('{1'b0, k, t, 1'b0});
            if (k < last_k) t += gaps[k] + 2;
        end
        if (last_k == N - 1) sb.push_back('{1'b1, N - 1, t + 1, 1'b0});

        @(posedge clk); #1;
        if (drop_req) new_coefficient_set = 1'b0;
        for (int unsigned k = 0; k < last_k; k++) begin
            modwait = 1'($urandom);
            @(posedge clk); #1;
            repeat (gaps[k]) begin
                modwait = 1'b1;
                @(posedge clk); #1;
            end
            modwait = 1'b0;
            @(posedge clk); #1;
        end
        if (last_k == N - 1) begin
            modwait = 1'($urandom);
            @(posedge clk); #1;
            new_coefficient_set = chain;
            modwait = 1'($urandom);
            @(posedge clk); #1;
        end else begin
            new_coefficient_set = 1'b0;
            modwait = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            #2 n_reset = 1'b0;
            #1 reset_checks("mid_reset");
            @(posedge clk); #1;
            n_reset = 1'b1;
            modwait = 1'b0;
        end
    endtask

`ifdef COEFF_LOADER_TIMEOUT_EN
    task automatic run_timeout();
        int unsigned t;
        new_coefficient_set = 1'b1;
        modwait = 1'b0;
        t = cyc + 1;
        sb.push_back('{1'b0, 0, t, 1'b0});
        sb.push_back('{1'b1, 0, t + T + 1, 1'b1});
        @(posedge clk); #1;
        modwait = 1'b1;
        repeat (T + 1) begin
            @(posedge clk); #1;
        end
        new_coefficient_set = 1'b0;
        @(posedge clk); #1;
        modwait = 1'b0;
    endtask
`endif

    initial begin
        repeat (2) @(posedge clk);
        #1 reset_checks("por");
        n_reset = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 0);

        run_seq(0, 1, 0, N - 1, 0, 1);
        run_seq(0, 0, 0, N - 1, 3, 1);
        run_seq(4, 0, 1, N - 1, 0, 1);
        for (int i = 0; i < 10; i++) begin
            bit ch;
            ch = 1'($urandom);
            run_seq($urandom_range(0, 3), 1'($urandom), ch, N - 1, 0, 0);
            if (!ch) begin
                repeat ($urandom_range(1, 3)) begin
                    modwait = 1'($urandom);
                    @(posedge clk); #1;
                end
            end
        end

`ifdef COEFF_LOADER_TIMEOUT_EN
        run_timeout();
        check("err_sticky", 32'(timeout_err), 1);
        check("err_idle_busy", 32'(busy), 0);
        run_seq(0, 0, 0, N - 1, 0, 1);
`else
        run_seq(0, 0, 0, N - 1, 120, 1);
        check("no_timeout", 32'(timeout_err), 0);
`endif

        run_seq(0, 0, 0, 2, 0, 0);
        check("post_reset_queue", 32'(sb.size()), 0);
        run_seq(1, 0, 0, N - 1, 0, 0);

        repeat (3) begin
            @(posedge clk); #1;
        end
        check("queue_drained", 32'(sb.size()), 0);
        check("final_idle", 32'(busy), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
